sad_result_collector: RTL and testbench

SAD_RESULT_COLLECTOR -- requirements
Module: sad_result_collector

---
 rtl/sad_result_collector_if.sv | 28 ++
 rtl/sad_result_collector.sv | 145 ++++++++++++++
 tb/tb_sad_result_collector.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sad_result_collector_if.sv
// PE-array to result-consumer bus for sad_result_collector.
// slave = collector side, master = PE controller / result consumer side.
interface sad_result_collector_if;
    logic        in_curr_enable;
    logic        CB_select;
    logic [1:0]  abs_Control;
    logic        row_sad_valid;
    logic [11:0] row_sad;
    logic        result_ready;
    logic        result_valid;
    logic [1:0]  result_idx;
    logic [15:0] result_sad;
    logic [4:0]  result_mvx;
    logic [4:0]  result_mvy;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  in_curr_enable, CB_select, abs_Control, row_sad_valid, row_sad, result_ready,
        output result_valid, result_idx, result_sad, result_mvx, result_mvy, busy, done, err
    );

    modport master (
        output in_curr_enable, CB_select, abs_Control, row_sad_valid, row_sad, result_ready,
        input  result_valid, result_idx, result_sad, result_mvx, result_mvy, busy, done, err
    );
endinterface

// File: rtl/sad_result_collector.sv
// Accumulates row SADs into per-sub-block candidate sums, tracks the best motion vector per
// sub-block and reads the four results out. Define SAD_TIE_LAST_EN to let the latest equal sum win.
module sad_result_collector (
    input  logic                        clk,
    input  logic                        rst,
    sad_result_collector_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, READOUT} state_t;

    state_t      state;
    logic [15:0] acc      [4];
    logic [3:0]  row_cnt  [4];
    logic [4:0]  cand_row [4];
    logic [15:0] best_sad [4];
    logic [4:0]  best_mvx [4];
    logic [4:0]  best_mvy [4];
    logic [4:0]  col_cnt;

    logic        res_valid_q;
    logic [1:0]  res_idx_q;
    logic [15:0] res_sad_q;
    logic [4:0]  res_mvx_q;
    logic [4:0]  res_mvy_q;
    logic        done_q;
    logic        err_q;

    logic [1:0]  k;
    logic [15:0] sum;
    logic        better;
    logic        start;
    logic        row_ok;
    logic        row_bad;
    logic [1:0]  next_idx;

    assign k        = bus.abs_Control;
    assign sum      = acc[k] + {4'b0, bus.row_sad};
    assign next_idx = res_idx_q + 2'd1;
    // Init/abort is only honoured outside READOUT; it also takes priority over any row that cycle.
    assign start    = bus.in_curr_enable && (state != READOUT);
    assign row_ok   = (state == ACCUM) && bus.row_sad_valid && (bus.abs_Control[1] == ~bus.CB_select);
    assign row_bad  = (state == ACCUM) && bus.row_sad_valid && (bus.abs_Control[1] == bus.CB_select);

`ifdef SAD_TIE_LAST_EN
    assign better = (sum <= best_sad[k]);
`else
    assign better = (sum < best_sad[k]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col_cnt     <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_sad_q   <= '0;
            res_mvx_q   <= '0;
            res_mvy_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                acc[i]      <= '0;
                row_cnt[i]  <= '0;
                cand_row[i] <= '0;
                best_sad[i] <= '1;
                best_mvx[i] <= '0;
                best_mvy[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state   <= ACCUM;
                col_cnt <= '0;
                err_q   <= 1'b0;
                for (int unsigned i = 0; i < 4; i++) begin
                    acc[i]      <= '0;
                    row_cnt[i]  <= '0;
                    cand_row[i] <= '0;
                    best_sad[i] <= '1;
                end
            end else begin
                case (state)
                    ACCUM: begin
                        if (row_bad)
                            err_q <= 1'b1;
                        if (row_ok) begin
                            if (row_cnt[k] == 4'd15) begin
                                if (better) begin
                                    best_sad[k] <= sum;
                                    best_mvx[k] <= col_cnt;
                                    best_mvy[k] <= cand_row[k];
                                end
                                acc[k]      <= '0;
                                row_cnt[k]  <= '0;
                                cand_row[k] <= cand_row[k] + 5'd1;
                                // Sub-block 3 closes a column; the last column hands over to readout.
                                if (k == 2'd3 && cand_row[3] == 5'd31) begin
                                    col_cnt <= col_cnt + 5'd1;
                                    if (col_cnt == 5'd31) begin
                                        state       <= READOUT;
                                        res_valid_q <= 1'b1;
                                        res_idx_q   <= 2'd0;
                                        res_sad_q   <= best_sad[0];
                                        res_mvx_q   <= best_mvx[0];
                                        res_mvy_q   <= best_mvy[0];
                                    end
                                end
                            end else begin
                                acc[k]     <= sum;
                                row_cnt[k] <= row_cnt[k] + 4'd1;
                            end
                        end
                    end
                    READOUT: begin
                        if (res_valid_q && bus.result_ready) begin
                            if (res_idx_q == 2'd3) begin
                                state       <= IDLE;
                                res_valid_q <= 1'b0;
                                res_idx_q   <= '0;
                                res_sad_q   <= '0;
                                res_mvx_q   <= '0;
                                res_mvy_q   <= '0;
                                done_q      <= 1'b1;
                            end else begin
                                res_idx_q <= next_idx;
                                res_sad_q <= best_sad[next_idx];
                                res_mvx_q <= best_mvx[next_idx];
                                res_mvy_q <= best_mvy[next_idx];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.result_valid = res_valid_q;
    assign bus.result_idx   = res_idx_q;
    assign bus.result_sad   = res_sad_q;
    assign bus.result_mvx   = res_mvx_q;
    assign bus.result_mvy   = res_mvy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_sad_result_collector.sv
// Directed bench for sad_result_collector: stimulus pushes expected result words into a queue,
// a separate monitor pops and compares them on every accepted handshake.
module tb_sad_result_collector;
    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] sad;
        logic [4:0]  mvx;
        logic [4:0]  mvy;
    } word_t;

`ifdef SAD_TIE_LAST_EN
    localparam logic [4:0] TIE_ROW = 5'd9;
    localparam logic [4:0] LAST_MV = 5'd31;
`else
    localparam logic [4:0] TIE_ROW = 5'd3;
    localparam logic [4:0] LAST_MV = 5'd0;
`endif

    logic  clk = 1'b0;
    logic  rst;
    word_t exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    sad_result_collector_if bus();

    sad_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic feed_row(input logic [1:0] k, input logic [11:0] v, input logic cb);
        @(negedge clk);
        bus.CB_select     = cb;
        bus.abs_Control   = k;
        bus.row_sad       = v;
        bus.row_sad_valid = 1'b1;
    endtask

    task automatic feed_cand(input logic [1:0] k, input logic [11:0] v);
        for (int r = 0; r < 16; r++)
            feed_row(k, v, ~k[1]);
    endtask

    task automatic idle_in;
        @(negedge clk);
        bus.row_sad_valid  = 1'b0;
        bus.in_curr_enable = 1'b0;
    endtask

    task automatic start_search;
        @(negedge clk);
        bus.row_sad_valid  = 1'b0;
        bus.in_curr_enable = 1'b1;
        @(negedge clk);
        bus.in_curr_enable = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        check("err_after_start", {31'b0, bus.err}, 32'd0);
    endtask

    task automatic push_word(input logic [1:0] i, input logic [15:0] s, input logic [4:0] x, input logic [4:0] y);
        word_t w;
        w.idx = i; w.sad = s; w.mvx = x; w.mvy = y;
        exp_q.push_back(w);
    endtask

    task automatic expect_done_once;
        int pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("done_pulse_count", pulses, 32'd1);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        check("idle_valid", {31'b0, bus.result_valid}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin : monitor
        word_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0 && bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL word_unexpected: got idx %0d sad %0h, expected none", bus.result_idx, bus.result_sad);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.result_idx, bus.result_sad, bus.result_mvx, bus.result_mvy} !== e) begin
                        n_bad++;
                        $display("FAIL word_idx%0d: got idx %0d sad %0h mv (%0d,%0d), expected idx %0d sad %0h mv (%0d,%0d)",
                                 e.idx, bus.result_idx, bus.result_sad, bus.result_mvx, bus.result_mvy,
                                 e.idx, e.sad, e.mvx, e.mvy);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst                = 1'b1;
        bus.in_curr_enable = 1'b0;
        bus.CB_select      = 1'b0;
        bus.abs_Control    = '0;
        bus.row_sad_valid  = 1'b0;
        bus.row_sad        = '0;
        bus.result_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        rst = 1'b0;

        // Search 1: full sweep with a zero-SAD candidate at (5,7) of sub-block 2, plus a mismatch row.
        push_word(2'd0, 16'd16, 5'd0, 5'd0);
        push_word(2'd1, 16'd16, 5'd0, 5'd0);
        push_word(2'd2, 16'd0, 5'd5, 5'd7);
        push_word(2'd3, 16'd16, LAST_MV, LAST_MV);
        start_search;
        feed_row(2'd2, 12'd100, 1'b1);
        idle_in;
        check("err_on_mismatch", {31'b0, bus.err}, 32'd1);
        feed_cand(2'd0, 12'd1);
        feed_cand(2'd1, 12'd1);
        for (int col = 0; col < 32; col++) begin
            if (col == 5)
                for (int c = 0; c < 8; c++)
                    feed_cand(2'd2, (c == 7) ? 12'd0 : 12'd1);
            for (int c = 0; c < 32; c++)
                feed_cand(2'd3, 12'd1);
        end
        idle_in;
        bus.result_ready = 1'b1;
        n = 0;
        while (!(bus.result_valid === 1'b1 && bus.result_idx === 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("readout_reached_idx1", {31'b0, n < 200}, 32'd1);
        bus.result_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, bus.result_valid}, 32'd1);
            check("stall_idx", {30'b0, bus.result_idx}, 32'd1);
            check("stall_sad", {16'b0, bus.result_sad}, 32'd16);
        end
        bus.result_ready = 1'b1;
        expect_done_once;
        check("err_sticky", {31'b0, bus.err}, 32'd1);

        // Search 3: reset mid-sweep at col 12 with err set and a good sub-block 2 best already stored.
        start_search;
        for (int r = 0; r < 16; r++)
            feed_row(2'd2, (r == 0) ? 12'd5 : 12'd0, 1'b0);
        feed_row(2'd0, 12'd7, 1'b0);
        for (int col = 0; col < 12; col++)
            for (int c = 0; c < 32; c++)
                feed_cand(2'd3, 12'd1);
        for (int r = 0; r < 3; r++)
            feed_row(2'd3, 12'd1, 1'b0);
        @(negedge clk);
        bus.row_sad_valid = 1'b0;
        check("pre_rst_err", {31'b0, bus.err}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_err", {31'b0, bus.err}, 32'd0);
        check("midrst_valid", {31'b0, bus.result_valid}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'b0, bus.busy}, 32'd0);

        // Search 2: 160 candidate for sub-block 0, tie of 32 at rows 3 and 9 for sub-block 1.
        push_word(2'd0, 16'd160, 5'd0, 5'd0);
        push_word(2'd1, 16'd32, 5'd0, TIE_ROW);
        push_word(2'd2, 16'hFFFF, 5'd0, 5'd0);
        push_word(2'd3, 16'd16, LAST_MV, LAST_MV);
        start_search;
        feed_cand(2'd0, 12'd10);
        for (int c = 0; c < 10; c++)
            feed_cand(2'd1, (c == 3 || c == 9) ? 12'd2 : 12'd3);
        for (int col = 0; col < 32; col++)
            for (int c = 0; c < 32; c++)
                feed_cand(2'd3, 12'd1);
        idle_in;
        expect_done_once;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
